double_pulse_meas: RTL

Receive-side counterpart of the double-pulse generator. Samples one external pulse line and measures, in sys_clk cycles, the first pulse high width, the low gap, and the second pulse high width. Reports the three values with a one-cycle valid strobe, or an error strobe with a cause code. Used for loopback self-check of the generator output and for characterising external double-pulse sources.

---
 rtl/double_pulse_meas.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/double_pulse_meas.sv
// double_pulse_meas: measures first-pulse width, gap and second-pulse width of a double pulse in sys_clk cycles.
// Optional glitch filter between synchroniser and edge detect when DPM_GLITCH_FILTER_EN is defined.
module double_pulse_meas #(
  parameter int CNT_W       = 7,
  parameter int TIMEOUT_CYC = 1000,
  parameter int FILT_LEN    = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] meas_width1,
  output logic [CNT_W-1:0] meas_gap,
  output logic [CNT_W-1:0] meas_width2,
  output logic             meas_valid,
  output logic             meas_err,
  output logic [1:0]       err_code,
  output logic             busy
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  typedef enum logic [2:0] {IDLE, P1, GAP, P2, DONE, WAIT_LOW} state_t;
  if (FILT_LEN < 1 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("double_pulse_meas: FILT_LEN must be >= 1 and TIMEOUT_CYC >= 2");
  end
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic pulse_s, pulse_d_q, rise, fall, tmo, cap_sat, sat_q, sat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, w1_q, w1_d, gap_q, gap_d;
  logic [CNT_W-1:0] meas_width1_q, meas_width1_d, meas_gap_q, meas_gap_d, meas_width2_q, meas_width2_d;
  logic meas_valid_q, meas_valid_d, meas_err_q, meas_err_d;
  logic [1:0] err_code_q, err_code_d;
  logic [TW-1:0] ph_q, ph_d;
`ifdef DPM_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  logic filt_q, filt_d, filt_hit;
  logic [FW-1:0] fc_q, fc_d;
  always_comb begin
    filt_hit = (sync_q[1] != filt_q) && (fc_q == FW'(FILT_LEN - 1));
    filt_d = filt_hit ? sync_q[1] : filt_q;
    fc_d = (sync_q[1] == filt_q || filt_hit) ? '0 : fc_q + 1'b1;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      filt_q <= 1'b0;
      fc_q <= '0;
    end else begin
      filt_q <= filt_d;
      fc_q <= fc_d;
    end
  assign pulse_s = filt_q;
`else
  assign pulse_s = sync_q[1];
`endif
  always_comb begin
    rise = pulse_s & ~pulse_d_q;
    fall = ~pulse_s & pulse_d_q;
    tmo = ph_q == TLAST;
    cap_sat = sat_q | (cnt_q == CMAX);
    cnt_d = (rise | fall) ? CNT_W'(1) : (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
    state_d = state_q;
    sat_d = sat_q;
    w1_d = w1_q;
    gap_d = gap_q;
    meas_width1_d = meas_width1_q;
    meas_gap_d = meas_gap_q;
    meas_width2_d = meas_width2_q;
    meas_valid_d = 1'b0;
    meas_err_d = 1'b0;
    err_code_d = err_code_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = rise ? P1 : IDLE;
        sat_d = rise ? 1'b0 : sat_q;
      end
      P1:
        if (fall) begin
          w1_d = cnt_q;
          sat_d = cap_sat;
          state_d = GAP;
        end else if (tmo) begin
          meas_err_d = 1'b1;
          err_code_d = 2'b01;
          state_d = WAIT_LOW;
        end
      GAP:
        if (rise) begin
          gap_d = cnt_q;
          sat_d = cap_sat;
          state_d = P2;
        end else if (tmo) begin
          meas_err_d = 1'b1;
          err_code_d = 2'b10;
          state_d = IDLE;
        end
      P2:
        if (fall) begin
          meas_width1_d = w1_q;
          meas_gap_d = gap_q;
          meas_width2_d = cnt_q;
          meas_valid_d = 1'b1;
          err_code_d = {2{cap_sat}};
          state_d = DONE;
        end else if (tmo) begin
          meas_err_d = 1'b1;
          err_code_d = 2'b01;
          state_d = WAIT_LOW;
        end
      WAIT_LOW: state_d = pulse_s ? WAIT_LOW : IDLE;
      default: state_d = IDLE;
    endcase
    ph_d = (state_d != state_q) ? '0 : ph_q + 1'b1;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q <= IDLE;
      sync_q <= '0;
      pulse_d_q <= 1'b0;
      cnt_q <= '0;
      ph_q <= '0;
      sat_q <= 1'b0;
      w1_q <= '0;
      gap_q <= '0;
      meas_width1_q <= '0;
      meas_gap_q <= '0;
      meas_width2_q <= '0;
      meas_valid_q <= 1'b0;
      meas_err_q <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[0], pulse_in};
      pulse_d_q <= pulse_s;
      cnt_q <= cnt_d;
      ph_q <= ph_d;
      sat_q <= sat_d;
      w1_q <= w1_d;
      gap_q <= gap_d;
      meas_width1_q <= meas_width1_d;
      meas_gap_q <= meas_gap_d;
      meas_width2_q <= meas_width2_d;
      meas_valid_q <= meas_valid_d;
      meas_err_q <= meas_err_d;
      err_code_q <= err_code_d;
    end
  assign meas_width1 = meas_width1_q;
  assign meas_gap = meas_gap_q;
  assign meas_width2 = meas_width2_q;
  assign meas_valid = meas_valid_q;
  assign meas_err = meas_err_q;
  assign err_code = err_code_q;
  assign busy = state_q != IDLE;
endmodule
